alu_div_unit: RTL and testbench
===============================

Name: alu_div_unit

Overview:
- Multi-cycle signed divider in the execute stage of the mMips datapath.
- Responds to the "magic" ALU control code 0x30 (hardware division) produced by the ALU controller.
- Radix-2 restoring division, one quotient bit per cycle.
- Stalls the pipeline while busy; presents quotient and remainder for writeback to lo/hi when done.

Parameters:
- WIDTH, 32: operand/result width in bits.
- CTRL_DIV, 6'h30: ALU control code that launches a division.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ALUctrl  in  6  ALU control code from the ALU controller.
- start  in  1  execute stage holds a valid instruction this cycle.
- dividend  in  WIDTH  operand A (rs), two's complement.
- divisor  in  WIDTH  operand B (rt), two's complement.
- stall  out  1  pipeline hold request.
- done  out  1  one-cycle pulse; results valid.
- quotient  out  WIDTH  signed quotient (to lo).
- remainder  out  WIDTH  signed remainder (to hi).
- div_by_zero  out  1  last division had divisor == 0.

Behaviour:
- Reset (async, any state): state=IDLE; stall=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal registers cleared.
- Accept condition: start=1 and ALUctrl==CTRL_DIV, in state IDLE or DONE. Other ALUctrl codes are ignored.
- On accept: capture |dividend|, |divisor|, sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend). Clear div_by_zero.
- stall is combinational: 1 in the accept cycle, and in CALC and FIX; 0 in IDLE (no accept) and in DONE.
- States:
  - IDLE: wait for accept. Go to CALC, or to ZERO if divisor==0.
  - CALC: WIDTH iterations. Each cycle: partial remainder = (rem<<1)|next dividend bit; if it is >= |divisor|, subtract and shift in a quotient 1, else shift in 0. Iteration counter counts 0..WIDTH-1; go to FIX after the last one.
  - FIX: negate the quotient if sign_q, negate the remainder if sign_r. Register both outputs. Go to DONE.
  - ZERO: quotient=all ones, remainder=dividend unmodified, div_by_zero=1. Go to DONE.
  - DONE: done=1 for exactly this cycle. Go to IDLE, or directly to CALC/ZERO on a back-to-back accept.
- Latency, accept in cycle 0:
  - Normal division: done in cycle WIDTH+2 (34 for WIDTH=32).
  - Divide by zero: done in cycle 2.
- quotient, remainder and div_by_zero hold their values after done until the next FIX/ZERO writes them.
- Arithmetic: magnitudes are WIDTH-bit unsigned; -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which is representable unsigned.
  - Overflow case -2^31 / -1 yields quotient 0x80000000, remainder 0. No trap.
  - Remainder sign always follows the dividend; |remainder| < |divisor|.
- start is ignored while in CALC/FIX/ZERO. The pipeline is stalled then, so it is not expected.
- Reset asserted mid-operation aborts immediately. No done pulse; outputs return to 0.

Decomposition:
- Shared package holds:
  - ALU control code constants CTRL_DIV=6'h30 and CTRL_CLIP=6'h31, shared with the ALU controller.
  - State encoding: IDLE, CALC, FIX, ZERO, DONE.
- One natural sub-module: div_step. Combinational single restoring iteration. Inputs: partial remainder, next dividend bit, divisor magnitude. Outputs: new remainder, quotient bit.
- The top-level holds the FSM, counter, sign logic and output registers.

Test Plan:
- 100 / 7 accepted in cycle 0 → stall=1 in cycles 0..33; done pulse in cycle 34 with quotient=14, remainder=2, div_by_zero=0.
- -7 / 2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); 7 / -2 → quotient=-3, remainder=1.
- 5 / 0 → done in cycle 2, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. A following 9 / 3 clears div_by_zero and gives quotient=3, remainder=0.
- 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. Back-to-back accept in the DONE cycle of 100/7 starts the next division with no idle cycle.
- start=1 with ALUctrl=0x02 or 0x31 → stall=0, no done, outputs unchanged.
- rst pulsed in cycle 10 of a division → stall, done, quotient and remainder go to 0 immediately, with no done pulse. The next division completes correctly.

Source files
------------

// File: rtl/alu_div_unit_pkg.sv
// Shared definitions for the mMips execute-stage divider: ALU control
// codes (also used by the ALU controller) and the divider state encoding.
package alu_div_unit_pkg;

   // ALU control codes shared with the ALU controller
   localparam logic [5:0] CTRL_DIV  = 6'h30;
   localparam logic [5:0] CTRL_CLIP = 6'h31;

   // Divider sequencing states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CALC = 3'd1,
      ST_FIX  = 3'd2,
      ST_ZERO = 3'd3,
      ST_DONE = 3'd4
   } div_state_e;

endpackage : alu_div_unit_pkg

// File: rtl/alu_div_unit_div_step.sv
// One radix-2 restoring division iteration: shift the next dividend bit
// into the partial remainder and subtract the divisor magnitude if it fits.
module alu_div_unit_div_step
   import alu_div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   // The shifted remainder is kept one bit wider so the compare never overflows.
   logic [WIDTH:0] trial_s;
   logic [WIDTH:0] dvs_ext_s;

   // Trial subtraction and restore decision
   always_comb begin
      trial_s   = {rem_i, bit_i};
      dvs_ext_s = {1'b0, dvs_i};
      if (trial_s >= dvs_ext_s) begin
         rem_o = WIDTH'(trial_s - dvs_ext_s);
         q_o   = 1'b1;
      end else begin
         rem_o = trial_s[WIDTH-1:0];
         q_o   = 1'b0;
      end
   end

endmodule : alu_div_unit_div_step

// File: rtl/alu_div_unit.sv
// Multi-cycle signed divider for the mMips execute stage. Divides operand
// magnitudes with a restoring algorithm (one quotient bit per cycle), then
// applies signs: quotient sign is the XOR of operand signs, remainder sign
// follows the dividend. Divide by zero short-circuits to all-ones quotient.
module alu_div_unit
   import alu_div_unit_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter logic [5:0]  CTRL_DIV = alu_div_unit_pkg::CTRL_DIV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       ALUctrl,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned      CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Two's complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
   function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      if (v[WIDTH-1]) begin
         r = -v;
      end else begin
         r = v;
      end
      return r;
   endfunction

   // Conditional negation used when applying result signs.
   function automatic logic [WIDTH-1:0] neg_if_f(input logic [WIDTH-1:0] v,
                                                 input logic neg);
      logic [WIDTH-1:0] r;
      if (neg) begin
         r = -v;
      end else begin
         r = v;
      end
      return r;
   endfunction

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;        // partial remainder
   logic [WIDTH-1:0] dvd_q, dvd_d;        // dividend magnitude, consumed MSB first
   logic [WIDTH-1:0] dvs_q, dvs_d;        // divisor magnitude
   logic [WIDTH-1:0] quo_q, quo_d;        // unsigned quotient under construction
   logic             sgn_quo_q, sgn_quo_d;
   logic             sgn_rem_q, sgn_rem_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;
   logic             done_q, done_d;

   logic             accept_s;
   logic [WIDTH-1:0] step_rem_s;
   logic             step_q_s;

   alu_div_unit_div_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .rem_i (rem_q),
      .bit_i (dvd_q[WIDTH-1]),
      .dvs_i (dvs_q),
      .rem_o (step_rem_s),
      .q_o   (step_q_s)
   );

   // State, datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         quo_q       <= '0;
         sgn_quo_q   <= 1'b0;
         sgn_rem_q   <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         quo_q       <= quo_d;
         sgn_quo_q   <= sgn_quo_d;
         sgn_rem_q   <= sgn_rem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         done_q      <= done_d;
      end
   end

   // Accept decode, next-state and datapath update
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      quo_d       = quo_q;
      sgn_quo_d   = sgn_quo_q;
      sgn_rem_d   = sgn_rem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      done_d      = 1'b0;

      accept_s = start && (ALUctrl == CTRL_DIV) &&
                 ((state_q == ST_IDLE) || (state_q == ST_DONE));

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept_s) begin
               dvd_d     = mag_f(dividend);
               dvs_d     = mag_f(divisor);
               sgn_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               sgn_rem_d = dividend[WIDTH-1];
               rem_d     = '0;
               quo_d     = '0;
               cnt_d     = '0;
               dbz_d     = 1'b0;
               if (divisor == '0) begin
                  state_d = ST_ZERO;
               end else begin
                  state_d = ST_CALC;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            rem_d = step_rem_s;
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            quo_d = {quo_q[WIDTH-2:0], step_q_s};
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FIX;
            end else begin
               state_d = ST_CALC;
            end
         end
         ST_FIX: begin
            quotient_d  = neg_if_f(quo_q, sgn_quo_q);
            remainder_d = neg_if_f(rem_q, sgn_rem_q);
            done_d      = 1'b1;
            state_d     = ST_DONE;
         end
         ST_ZERO: begin
            // Rebuild the original dividend from its captured magnitude and sign.
            quotient_d  = '1;
            remainder_d = neg_if_f(dvd_q, sgn_rem_q);
            dbz_d       = 1'b1;
            done_d      = 1'b1;
            state_d     = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Pipeline hold: the accept cycle plus every busy state
   always_comb begin
      stall = accept_s || (state_q == ST_CALC) || (state_q == ST_FIX) ||
              (state_q == ST_ZERO);
   end

   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule : alu_div_unit

// File: tb/tb_alu_div_unit.sv
// Directed testbench for alu_div_unit with hand-computed expected results.
module tb_alu_div_unit;

   localparam int W = 32;

   logic          clk;
   logic          rst;
   logic [5:0]    ALUctrl;
   logic          start;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic          stall;
   logic          done;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          div_by_zero;

   int n_total = 0;
   int n_bad   = 0;

   alu_div_unit #(
      .WIDTH    (W),
      .CTRL_DIV (6'h30)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ALUctrl     (ALUctrl),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .stall       (stall),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Present a division in the current cycle (caller is just after a negedge).
   task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b);
      ALUctrl  = 6'h30;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      #1;
      chk({tag, "_stall_c0"}, {31'd0, stall}, 32'd1);
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = 32'hDEAD_BEEF;
      divisor  = 32'h1234_5678;
   endtask

   // Wait for done; returns positioned at the negedge of the done cycle.
   task automatic wait_done(input string tag, input logic [31:0] eq, input logic [31:0] er,
                            input logic edbz, input int elat);
      int  cyc;
      bit  seen;
      bit  stall_ok;
      cyc      = 1;
      seen     = 1'b0;
      stall_ok = 1'b1;
      while (!seen && cyc <= 60) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
         end else begin
            if (!stall) stall_ok = 1'b0;
            cyc++;
         end
      end
      if (!seen) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         chk({tag, "_latency"}, cyc, elat);
         chk({tag, "_busy_stall"}, {31'd0, stall_ok}, 32'd1);
         chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
         chk({tag, "_quo"}, quotient, eq);
         chk({tag, "_rem"}, remainder, er);
         chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
      end
   endtask

   task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                         input int elat);
      @(negedge clk);
      issue(tag, a, b);
      wait_done(tag, eq, er, edbz, elat);
   endtask

   initial begin
      bit quiet;
      rst      = 1'b1;
      ALUctrl  = 6'h00;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(negedge clk);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_quo", quotient, 32'd0);
      chk("rst_rem", remainder, 32'd0);
      chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      rst = 1'b0;

      do_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
      do_div("dm7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
      do_div("d7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34);
      do_div("d5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2);
      do_div("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);
      do_div("dm5_0", 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 2);
      do_div("dmax_1", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 34);

      // Back-to-back: second division accepted in the DONE cycle of the first
      do_div("b2b_a", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
      issue("b2b_b", 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("b2b_b", 32'h8000_0000, 32'd0, 1'b0, 34);

      // Non-divide ALU codes must be ignored
      @(negedge clk);
      ALUctrl  = 6'h02;
      start    = 1'b1;
      dividend = 32'd20;
      divisor  = 32'd4;
      #1;
      chk("ign02_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      ALUctrl = 6'h31;
      #1;
      chk("ign31_stall", {31'd0, stall}, 32'd0);
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || stall) quiet = 1'b0;
      end
      chk("ign_quiet", {31'd0, quiet}, 32'd1);
      chk("ign_quo", quotient, 32'h8000_0000);
      chk("ign_rem", remainder, 32'd0);
      start   = 1'b0;
      ALUctrl = 6'h00;

      // Reset in cycle 10 of a division aborts it
      @(negedge clk);
      issue("abort", 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_stall", {31'd0, stall}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_quo", quotient, 32'd0);
      chk("abort_rem", remainder, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || stall) quiet = 1'b0;
      end
      chk("abort_no_done", {31'd0, quiet}, 32'd1);
      do_div("post_rst", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_alu_div_unit
